bundle_issue_ctrl: RTL

Issue controller in front of the two-stage dual-issue bundle parser. Buffers 60-bit fetch bundles in a small FIFO and presents one bundle per cycle to the parser on its enable/instruction inputs. The parser has no backpressure, so this block does all throttling: credit-based flow control against the downstream decode queue, a branch-wait throttle, and flush/drain sequencing on redirect.

---
 rtl/pa_bundle_pkg.sv | 24 ++
 rtl/bundle_fifo.sv | 58 +++++
 rtl/bundle_issue_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pa_bundle_pkg.sv
// Shared definitions for the bundle issue controller: bundle width, the
// instruction-field bit positions, the issue-state encoding and branch detection.
package pa_bundle_pkg;

    localparam int BUNDLE_W      = 60;
    localparam int FMT_BIT       = 59;
    localparam int BR1_BIT       = 58;
    localparam int BR2_BIT_LONG  = 28;
    localparam int BR2_BIT_SHORT = 39;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_DRAIN   = 2'd2
    } issue_state_t;

    // The second instruction's branch bit moves depending on the format of the first
    function automatic logic bundle_has_branch(input logic [BUNDLE_W-1:0] bundle);
        logic br2;
        br2 = bundle[FMT_BIT] ? bundle[BR2_BIT_LONG] : bundle[BR2_BIT_SHORT];
        return bundle[BR1_BIT] | br2;
    endfunction

endpackage

// File: rtl/bundle_fifo.sv
// Small synchronous FIFO with occupancy count and a one-cycle clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module bundle_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 60
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count != CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are meaningless outside the count window so no reset
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and count update; clear and reset both drop a same-cycle push
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bundle_issue_ctrl.sv
// Issue controller in front of the dual-issue bundle parser: buffers fetch
// bundles, throttles issue on downstream credits, waits on branches and
// drains the parser after a redirect.
// Optional macro BRANCH_THROTTLE_EN enables the branch-wait state; without it
// branch bundles issue like any other and resolve_i is ignored.
module bundle_issue_ctrl
    import pa_bundle_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CREDITS   = 4,
    parameter int PARSE_LAT = 2
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        fetch_valid_i,
    input  logic [BUNDLE_W-1:0]         fetch_bundle_i,
    output logic                        fetch_ready_o,
    output logic                        parse_enable_o,
    output logic [BUNDLE_W-1:0]         parse_bundle_o,
    input  logic                        credit_return_i,
    input  logic                        resolve_i,
    input  logic                        flush_i,
    output logic [$clog2(DEPTH):0]      occupancy_o,
    output logic [$clog2(CREDITS):0]    credits_o,
    output logic                        err_o
);

    localparam int OCC_W   = $clog2(DEPTH) + 1;
    localparam int CRED_W  = $clog2(CREDITS) + 1;
    localparam int DRAIN_W = $clog2(PARSE_LAT + 1);

    issue_state_t         state;
    issue_state_t         state_next;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [DRAIN_W-1:0]   drain_next;
    logic [CRED_W-1:0]    credits;
    logic [OCC_W-1:0]     occupancy;
    logic [BUNDLE_W-1:0]  head;
    logic                 push;
    logic                 issue;

`ifndef BRANCH_THROTTLE_EN
    logic unused_resolve;
    assign unused_resolve = resolve_i;
`endif

    assign fetch_ready_o = !reset_i && (occupancy < OCC_W'(DEPTH)) && (state != ST_DRAIN);
    assign push          = fetch_valid_i && fetch_ready_o;
    assign issue         = (state == ST_RUN) && (occupancy != '0) && (credits != '0) && !flush_i;
    assign occupancy_o   = occupancy;
    assign credits_o     = credits;

    bundle_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BUNDLE_W)
    ) u_fifo (
        .clock   (clock_i),
        .reset   (reset_i),
        .push    (push),
        .pop     (issue),
        .clear   (flush_i),
        .wr_data (fetch_bundle_i),
        .rd_data (head),
        .count   (occupancy)
    );

    // Next-state logic; a redirect overrides everything and restarts the drain
    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        if (flush_i) begin
            state_next = ST_DRAIN;
            drain_next = DRAIN_W'(PARSE_LAT);
        end else begin
            case (state)
                ST_RUN: begin
`ifdef BRANCH_THROTTLE_EN
                    if (issue && bundle_has_branch(head)) begin
                        state_next = ST_BR_WAIT;
                    end
`endif
                end
`ifdef BRANCH_THROTTLE_EN
                ST_BR_WAIT: begin
                    if (resolve_i) begin
                        state_next = ST_RUN;
                    end
                end
`endif
                ST_DRAIN: begin
                    if (drain_cnt <= DRAIN_W'(1)) begin
                        state_next = ST_RUN;
                        drain_next = '0;
                    end else begin
                        drain_next = drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    drain_next = '0;
                end
            endcase
        end
    end

    // State and drain counter registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    // Credit accounting; a return with every slot already free is an overflow
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            credits <= CRED_W'(CREDITS);
            err_o   <= 1'b0;
        end else if (issue && !credit_return_i) begin
            credits <= credits - CRED_W'(1);
        end else if (!issue && credit_return_i) begin
            if (credits == CRED_W'(CREDITS)) begin
                err_o <= 1'b1;
            end else begin
                credits <= credits + CRED_W'(1);
            end
        end
    end

    // Parser drive registers; the bundle holds its value when nothing issues
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            parse_enable_o <= 1'b0;
            parse_bundle_o <= '0;
        end else begin
            parse_enable_o <= issue;
            if (issue) begin
                parse_bundle_o <= head;
            end
        end
    end

endmodule
